// File: rtl/tetris_score_if.sv
// Line-clear event handshake, game-control pulses and scoreboard outputs of the
// Tetris scoring block.
interface tetris_score_if;
  logic        clear_valid;
  logic [2:0]  clear_lines;
  logic        clear_ready;
  logic        soft_drop;
  logic        game_over;
  logic        new_game;
  logic [12:0] score;
  logic [3:0]  level;
  logic [7:0]  lines_total;
  logic        busy;
  logic        over;

  modport master (
    output clear_valid, clear_lines, soft_drop, game_over, new_game,
    input  clear_ready, score, level, lines_total, busy, over
  );

  modport slave (
    input  clear_valid, clear_lines, soft_drop, game_over, new_game,
    output clear_ready, score, level, lines_total, busy, over
  );
endinterface

// File: rtl/tetris_score.sv
// Tetris scoring: awards base points x (level+1) by repeated addition over
// level+1 cycles, tracks level and cleared lines, and drains soft-drop points.
module tetris_score (
  input  logic          clk,
  input  logic          rst,
  tetris_score_if.slave bus
);

  typedef enum logic [1:0] {IDLE, ADD, COMMIT, OVER} state_t;

  state_t      state, state_nxt;
  logic [10:0] base;
  logic [10:0] acc;
  logic [3:0]  cnt;
  logic [2:0]  n_lines;
  logic [3:0]  pending;
  logic [12:0] score_q;
  logic [3:0]  level_q;
  logic [7:0]  lines_q;
  logic [7:0]  lines_new;
  logic        accept;
  logic        drain;
  logic        drop_inc;

  function automatic logic [10:0] base_points(input logic [2:0] n);
    case (n)
      3'd1:    return 11'd4;
      3'd2:    return 11'd10;
      3'd3:    return 11'd30;
      3'd4:    return 11'd120;
      default: return 11'd0;
    endcase
  endfunction

  function automatic logic [12:0] sat_score(input logic [12:0] a, input logic [11:0] b);
    logic [13:0] s;
    s = {1'b0, a} + {2'b00, b};
    return s[13] ? 13'h1FFF : s[12:0];
  endfunction

  function automatic logic [7:0] sat_lines(input logic [7:0] a, input logic [2:0] b);
    logic [8:0] s;
    s = {1'b0, a} + {6'd0, b};
    return s[8] ? 8'hFF : s[7:0];
  endfunction

  function automatic logic [3:0] level_of(input logic [7:0] l);
    logic [7:0] q;
    q = l / 8'd10;
    return (q > 8'd9) ? 4'd9 : q[3:0];
  endfunction

  assign accept    = (state == IDLE) && bus.clear_valid && !bus.new_game && !bus.game_over;
  assign drain     = (state == IDLE) && !accept && (pending != 4'd0) &&
                     !bus.new_game && !bus.game_over;
  assign drop_inc  = bus.soft_drop && (state != OVER);
  assign lines_new = sat_lines(lines_q, n_lines);

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (accept) state_nxt = ADD;
      ADD:     if (cnt == 4'd0) state_nxt = COMMIT;
      COMMIT:  state_nxt = IDLE;
      default: state_nxt = OVER;
    endcase
    if (bus.game_over) state_nxt = OVER;
    if (bus.new_game)  state_nxt = IDLE;
  end

  // Award datapath: base and level snapshot taken on accept, summed during ADD
  always_ff @(posedge clk) begin
    if (bus.new_game) begin
      acc <= 11'd0;
    end else if (accept) begin
      base    <= base_points(bus.clear_lines);
      n_lines <= (bus.clear_lines > 3'd4) ? 3'd0 : bus.clear_lines;
      cnt     <= level_q;
      acc     <= 11'd0;
    end else if (state == ADD) begin
      acc <= acc + base;
      if (cnt != 4'd0) cnt <= cnt - 4'd1;
    end
  end

  // Scoreboard: commit of an award, or one soft-drop point per idle cycle
  always_ff @(posedge clk) begin
    if (rst || bus.new_game) begin
      score_q <= 13'd0;
      level_q <= 4'd0;
      lines_q <= 8'd0;
    end else if (!bus.game_over) begin
      if (state == COMMIT) begin
        score_q <= sat_score(score_q, {1'b0, acc});
        lines_q <= lines_new;
        level_q <= level_of(lines_new);
      end else if (drain) begin
        score_q <= sat_score(score_q, 12'd1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst || bus.new_game || bus.game_over) begin
      pending <= 4'd0;
    end else if (drop_inc && !drain) begin
      if (pending != 4'd15) pending <= pending + 4'd1;
    end else if (!drop_inc && drain) begin
      pending <= pending - 4'd1;
    end
  end

  assign bus.clear_ready = (state == IDLE);
  assign bus.busy        = (state == ADD) || (state == COMMIT);
  assign bus.over        = (state == OVER);
  assign bus.score       = score_q;
  assign bus.level       = level_q;
  assign bus.lines_total = lines_q;

endmodule

// File: tb/tb_tetris_score.sv
// Directed bench for tetris_score with hand-computed expected scores, levels,
// line totals and award latencies.
module tb_tetris_score;
  logic clk = 1'b0;
  logic rst;
  int   n_tests = 0;
  int   n_fail  = 0;
  int   bcyc;

  tetris_score_if bus ();

  tetris_score dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input int obs, input int exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Offer one event, then count cycles with busy high (bounded)
  task automatic send_clear(input logic [2:0] n, output int busy_cycles);
    bus.clear_valid = 1'b1;
    bus.clear_lines = n;
    step();
    bus.clear_valid = 1'b0;
    busy_cycles = 0;
    for (int i = 0; i < 20 && bus.busy; i++) begin
      busy_cycles++;
      step();
    end
  endtask

  initial begin
    rst             = 1'b1;
    bus.clear_valid = 1'b0;
    bus.clear_lines = 3'd0;
    bus.soft_drop   = 1'b0;
    bus.game_over   = 1'b0;
    bus.new_game    = 1'b0;
    step();
    step();
    rst = 1'b0;
    check("rst_score", bus.score, 0);
    check("rst_level", bus.level, 0);
    check("rst_lines", bus.lines_total, 0);
    check("rst_busy", bus.busy, 0);
    check("rst_over", bus.over, 0);
    check("rst_ready", bus.clear_ready, 1);

    // 4 lines at level 0: 120 visible at N+3
    bus.clear_valid = 1'b1;
    bus.clear_lines = 3'd4;
    step();
    bus.clear_valid = 1'b0;
    check("t4_busy_add", bus.busy, 1);
    check("t4_ready_add", bus.clear_ready, 0);
    step();
    check("t4_score_commit", bus.score, 0);
    step();
    check("t4_score", bus.score, 120);
    check("t4_lines", bus.lines_total, 4);
    check("t4_level", bus.level, 0);
    check("t4_busy_done", bus.busy, 0);

    // six single lines -> 10 lines, level 1
    for (int i = 0; i < 6; i++) send_clear(3'd1, bcyc);
    check("l10_score", bus.score, 144);
    check("l10_lines", bus.lines_total, 10);
    check("l10_level", bus.level, 1);

    // 2 lines at level 1: +20, busy for 3 cycles
    send_clear(3'd2, bcyc);
    check("d2_busy_cycles", bcyc, 3);
    check("d2_score", bus.score, 164);
    check("d2_lines", bus.lines_total, 12);

    // illegal line count: no score, no lines
    send_clear(3'd6, bcyc);
    check("c6_busy_cycles", bcyc, 3);
    check("c6_score", bus.score, 164);
    check("c6_lines", bus.lines_total, 12);

    // soft drops during the award, drained after commit
    bus.clear_valid = 1'b1;
    bus.clear_lines = 3'd1;
    step();
    bus.clear_valid = 1'b0;
    bus.soft_drop   = 1'b1;
    step();
    step();
    step();
    bus.soft_drop = 1'b0;
    check("sd_score_commit", bus.score, 172);
    check("sd_busy", bus.busy, 0);
    step();
    check("sd_drain1", bus.score, 173);
    step();
    check("sd_drain2", bus.score, 174);
    step();
    check("sd_drain3", bus.score, 175);
    step();
    check("sd_drain_end", bus.score, 175);
    check("sd_lines", bus.lines_total, 13);

    // game over mid-award freezes everything
    bus.clear_valid = 1'b1;
    bus.clear_lines = 3'd3;
    step();
    bus.clear_valid = 1'b0;
    bus.game_over   = 1'b1;
    step();
    bus.game_over = 1'b0;
    check("go_over", bus.over, 1);
    check("go_ready", bus.clear_ready, 0);
    check("go_busy", bus.busy, 0);
    check("go_score", bus.score, 175);
    bus.clear_valid = 1'b1;
    bus.clear_lines = 3'd4;
    bus.soft_drop   = 1'b1;
    step();
    bus.soft_drop = 1'b0;
    step();
    step();
    step();
    bus.clear_valid = 1'b0;
    check("go_frozen_score", bus.score, 175);
    check("go_frozen_lines", bus.lines_total, 13);
    check("go_frozen_level", bus.level, 1);
    check("go_still_over", bus.over, 1);

    bus.new_game = 1'b1;
    step();
    bus.new_game = 1'b0;
    check("ng_score", bus.score, 0);
    check("ng_level", bus.level, 0);
    check("ng_lines", bus.lines_total, 0);
    check("ng_over", bus.over, 0);
    check("ng_ready", bus.clear_ready, 1);
    step();
    check("ng_no_drain", bus.score, 0);

    // climb with 4-line events; multipliers 1,1,1,2,2,3,3,3,4,4,5,5,5,6,6,7,7
    for (int i = 0; i < 17; i++) send_clear(3'd4, bcyc);
    check("climb_score", bus.score, 7800);
    check("climb_lines", bus.lines_total, 68);
    check("climb_level", bus.level, 6);
    for (int i = 0; i < 6; i++) send_clear(3'd4, bcyc);
    check("sat_score", bus.score, 8191);
    check("sat_lines92", bus.lines_total, 92);
    check("sat_level", bus.level, 9);
    send_clear(3'd4, bcyc);
    check("l9_busy_cycles", bcyc, 11);
    check("l9_score", bus.score, 8191);
    check("l9_lines", bus.lines_total, 96);
    bus.soft_drop = 1'b1;
    step();
    bus.soft_drop = 1'b0;
    step();
    step();
    check("sat_soft_drop", bus.score, 8191);

    // lines_total saturates at 255
    for (int i = 0; i < 40; i++) send_clear(3'd4, bcyc);
    check("lines_sat", bus.lines_total, 255);
    check("lines_sat_level", bus.level, 9);
    send_clear(3'd1, bcyc);
    check("lines_sat_hold", bus.lines_total, 255);

    // reset in the middle of an award
    bus.new_game = 1'b1;
    step();
    bus.new_game = 1'b0;
    send_clear(3'd4, bcyc);
    check("pre_rst_score", bus.score, 120);
    bus.clear_valid = 1'b1;
    bus.clear_lines = 3'd4;
    step();
    bus.clear_valid = 1'b0;
    rst = 1'b1;
    step();
    rst = 1'b0;
    check("rst_mid_busy", bus.busy, 0);
    check("rst_mid_ready", bus.clear_ready, 1);
    step();
    step();
    step();
    check("rst_mid_score", bus.score, 0);
    check("rst_mid_lines", bus.lines_total, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/tetris_score.md
TETRIS_SCORE -- requirements
Module: tetris_score

Interface
REQ-001 SHALL expose: clk  input  1  single system clock, all state on rising edge.
REQ-002 SHALL expose: rst  input  1  synchronous, active-high reset.
REQ-003 SHALL expose: clear_valid  input  1  line-clear event offered.
REQ-004 SHALL expose: clear_lines  input  3  lines cleared by the event, legal 0-4.
REQ-005 SHALL expose: clear_ready  output  1  block can accept a line-clear event.
REQ-006 SHALL expose: soft_drop  input  1  one-cycle pulse, one soft-drop row.
REQ-007 SHALL expose: game_over  input  1  one-cycle pulse, freezes scoring.
REQ-008 SHALL expose: new_game  input  1  one-cycle pulse, restarts scoring.
REQ-009 SHALL expose: score  output  13  binary score, driven directly into the 4-digit seven-segment display driver.
REQ-010 SHALL expose: level  output  4  current level 0-9.
REQ-011 SHALL expose: lines_total  output  8  cumulative lines, saturating.
REQ-012 SHALL expose: busy  output  1  award computation in progress.
REQ-013 SHALL expose: over  output  1  game-over state.

Function
REQ-014 SHALL implement FSM states IDLE, ADD, COMMIT, OVER.
REQ-015 clear_ready SHALL be 1 only in IDLE; an event is accepted on a cycle where clear_valid and clear_ready are both 1.
REQ-016 On accept, SHALL latch base points (0 lines->0, 1->4, 2->10, 3->30, 4->120, 5-7->0 and lines treated as 0), load a 4-bit down-counter with level, clear an 11-bit accumulator, and go to ADD.
REQ-017 In ADD, SHALL add base to accumulator each cycle; when counter = 0 go to COMMIT, else decrement counter; award = base x (level+1), max 1200.
REQ-018 In COMMIT, SHALL set score = min(score + acc, 8191), lines_total = min(lines_total + n, 255), level = min(new lines_total / 10, 9), then go to IDLE.
REQ-019 Latency: event accepted at cycle N SHALL make updated score/level/lines_total visible at cycle N+3+level.
REQ-020 busy SHALL be 1 exactly in ADD and COMMIT.
REQ-021 soft_drop pulses in IDLE/ADD/COMMIT SHALL increment a 4-bit pending counter, saturating at 15. Pulses in OVER are ignored.
REQ-022 In IDLE, on a cycle with no accept and pending > 0, SHALL set score = min(score+1, 8191) and decrement pending. Accept has priority over this drain.
REQ-023 A simultaneous soft_drop and drain SHALL leave pending unchanged.
REQ-024 game_over from any state SHALL enter OVER: in-flight award discarded, pending cleared, score/level/lines_total frozen, over = 1, clear_ready = 0.
REQ-025 new_game from any state SHALL clear score, level, lines_total, pending, accumulator and enter IDLE next cycle.
REQ-026 Priority SHALL be rst > new_game > game_over > normal operation.
REQ-027 score SHALL never wrap; saturation holds at 8191 for all further additions.

Reset
REQ-028 On rst = 1, next edge SHALL produce: state IDLE, score 0, level 0, lines_total 0, pending 0, busy 0, over 0, clear_ready 1.
REQ-029 rst asserted mid-ADD/COMMIT SHALL discard the award, with no partial score update.

Verification
REQ-030 Reset, then accept clear_lines = 4 at level 0 -> score = 120 at N+3, lines_total = 4, level = 0.
REQ-031 Feed 1-line events until lines_total = 10 -> level becomes 1; next 2-line event -> +20 points, visible 4 cycles after accept, busy high 3 cycles.
REQ-032 Preload score near the limit (e.g. 8150) and accept a 4-line event at level 9 -> score saturates at 8191; a further soft_drop leaves 8191.
REQ-033 Three soft_drop pulses during ADD -> pending = 3, then score +1 on each of the first three IDLE cycles after COMMIT.
REQ-034 Assert game_over during ADD -> over = 1, score unchanged, clear_ready 0, clear_valid ignored; new_game -> all outputs 0, clear_ready 1 next cycle.
REQ-035 Apply clear_lines = 6 -> accepted, busy pulses, score and lines_total unchanged.
